// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Register-index width for a power-of-two register count.
    function automatic int rf_aw(input int nreg);
        int w;
        w = 0;
        while ((1 << w) < nreg) w++;
        return w;
    endfunction

    localparam int AW_DEF = rf_aw(NREG_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register plus a
// registered population count of the bits.
import rf_pkg::*;

module rf_scoreboard #(
    parameter int NREG = NREG_DEF,
    parameter int AW   = rf_aw(NREG_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy_vec,
    output logic [AW:0]     busy_cnt
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;

    // Priority: flush > reserve > write-complete, so a producer issued in the
    // same cycle as an older one completes keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en && wr_addr != '0)
                busy_d[wr_addr] = 1'b0;
            if (rsv_en && rsv_addr != '0)
                busy_d[rsv_addr] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NREG; i++)
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with x0 hardwired to zero and a busy-bit
// scoreboard. Define REG_FILE_SB_BYPASS_EN to forward same-cycle writes to reads.
import rf_pkg::*;

module reg_file_sb #(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    localparam int AW  = rf_aw(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            flush,
    output logic            busy1,
    output logic            busy2,
    output logic            stall,
    output logic [AW:0]     busy_cnt
);

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_vec;

    rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_vec (busy_vec),
        .busy_cnt (busy_cnt)
    );

    always_comb begin
        regs_d = regs_q;
        if (wr_en && wr_addr != '0)
            regs_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    // Busy bit 0 is never set, so x0 reads as idle without a special case.
    always_comb begin
        rd_data1 = (rd_addr1 != '0) ? regs_q[rd_addr1] : '0;
        rd_data2 = (rd_addr2 != '0) ? regs_q[rd_addr2] : '0;
        busy1    = busy_vec[rd_addr1];
        busy2    = busy_vec[rd_addr2];
`ifdef REG_FILE_SB_BYPASS_EN
        if (wr_en && wr_addr == rd_addr1 && rd_addr1 != '0) begin
            rd_data1 = wr_data;
            if (!(rsv_en && rsv_addr == rd_addr1)) busy1 = 1'b0;
        end
        if (wr_en && wr_addr == rd_addr2 && rd_addr2 != '0) begin
            rd_data2 = wr_data;
            if (!(rsv_en && rsv_addr == rd_addr2)) busy2 = 1'b0;
        end
`endif
    end

    assign stall = busy1 | busy2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic compared every cycle against an array-based reference model.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk, rst;
    logic [AW-1:0]   rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [XLEN-1:0] rd_data1, rd_data2, wr_data;
    logic            wr_en, rsv_en, flush;
    logic            busy1, busy2, stall;
    logic [AW:0]     busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .busy1(busy1), .busy2(busy2), .stall(stall), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural contents and the set of pending producers.
    logic [XLEN-1:0] mregs [NREG];
    logic            mbusy [NREG];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mregs[i] <= '0;
                mbusy[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i != 0 && wr_en && int'(wr_addr) == i) mregs[i] <= wr_data;
                if (i == 0 || flush)                        mbusy[i] <= 1'b0;
                else if (rsv_en && int'(rsv_addr) == i)     mbusy[i] <= 1'b1;
                else if (wr_en && int'(wr_addr) == i)       mbusy[i] <= 1'b0;
            end
        end
    end

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        logic [XLEN-1:0] d;
        d = (a == '0) ? '0 : mregs[a];
`ifdef REG_FILE_SB_BYPASS_EN
        if (wr_en && wr_addr == a && a != '0) d = wr_data;
`endif
        return d;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic b;
        b = (a == '0) ? 1'b0 : mbusy[a];
`ifdef REG_FILE_SB_BYPASS_EN
        if (wr_en && wr_addr == a && a != '0 && !(rsv_en && rsv_addr == a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_rd1",  rd_data1, exp_data(rd_addr1));
            chk("cyc_rd2",  rd_data2, exp_data(rd_addr2));
            chk("cyc_bsy1", 32'(busy1), 32'(exp_busy(rd_addr1)));
            chk("cyc_bsy2", 32'(busy2), 32'(exp_busy(rd_addr2)));
            chk("cyc_stal", 32'(stall), 32'(exp_busy(rd_addr1) | exp_busy(rd_addr2)));
            chk("cyc_cnt",  32'(busy_cnt), 32'(model_cnt()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
        wr_addr = '0; rsv_addr = '0; wr_data = '0;
    endtask

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG-1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        rd_addr1 = 5'd5; rd_addr2 = 5'd31;
        #12 rst = 1'b0;
        #1;
        chk("rst_rd1", rd_data1, 32'h0);
        chk("rst_rd2", rd_data2, 32'h0);
        chk("rst_bsy", 32'({busy1, busy2, stall}), 32'h0);
        chk("rst_cnt", 32'(busy_cnt), 32'h0);

        // Write x3, read it through both ports.
        step();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        rd_addr1 = 5'd3; rd_addr2 = 5'd3;
        #1;
`ifdef REG_FILE_SB_BYPASS_EN
        chk("x3_fwd", rd_data1, 32'hDEADBEEF);
`else
        chk("x3_old", rd_data1, 32'h0);
`endif
        step();
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h1234; #1;
        chk("x3_rd1", rd_data1, 32'hDEADBEEF);
        chk("x3_rd2", rd_data2, 32'hDEADBEEF);
        wr_en = 1'b1;
        step();
        idle(); rd_addr1 = 5'd0; #1;
        chk("x0_zero", rd_data1, 32'h0);

        // Reserve x7, then complete it.
        rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr1 = 5'd7;
        step();
        idle(); #1;
        chk("x7_busy",  32'(busy1), 32'h1);
        chk("x7_stall", 32'(stall), 32'h1);
        chk("x7_cnt",   32'(busy_cnt), 32'h1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        step();
        idle(); #1;
        chk("x7_clr",  32'(busy1), 32'h0);
        chk("x7_cnt0", 32'(busy_cnt), 32'h0);
        chk("x7_data", rd_data1, 32'h55);

        // Same-cycle reserve and write: new producer wins.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA;
        rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr1 = 5'd9;
        step();
        idle(); #1;
        chk("x9_data", rd_data1, 32'hA);
        chk("x9_busy", 32'(busy1), 32'h1);
        rsv_en = 1'b1; rsv_addr = 5'd2;
        step();
        rsv_addr = 5'd4;
        step();
        idle(); #1;
        chk("cnt3", 32'(busy_cnt), 32'h3);
        rsv_en = 1'b1; rsv_addr = 5'd2;
        step();
        rsv_en = 1'b1; rsv_addr = 5'd5; flush = 1'b1;
        step();
        idle(); rd_addr2 = 5'd5; #1;
        chk("flush_cnt", 32'(busy_cnt), 32'h0);
        chk("flush_rsv", 32'(busy2), 32'h0);
        chk("flush_dat", rd_data1, 32'hA);

        // Write x4 while reading it.
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77; rd_addr2 = 5'd4;
        #1;
`ifdef REG_FILE_SB_BYPASS_EN
        chk("x4_fwd", rd_data2, 32'h77);
`else
        chk("x4_old", rd_data2, 32'h0);
`endif
        chk("x4_bsy", 32'(busy2), 32'h0);
        step();
        idle();

        // Asynchronous reset between edges.
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h99;
        step();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd6; rd_addr1 = 5'd6;
        step();
        idle(); #1;
        chk("x6_pre", rd_data1, 32'h99);
        chk("x6_bsy", 32'(busy1), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("arst_rd",  rd_data1, 32'h0);
        chk("arst_bsy", 32'({busy1, stall}), 32'h0);
        chk("arst_cnt", 32'(busy_cnt), 32'h0);
        step();
        rst = 1'b0;

        // Randomized traffic with occasional mid-run resets.
        for (int c = 0; c < 2000; c++) begin
            step();
            rst      = ($urandom_range(0, 149) == 0);
            wr_en    = ($urandom_range(0, 1) == 0);
            wr_addr  = raddr();
            wr_data  = $urandom;
            rsv_en   = ($urandom_range(0, 9) < 4);
            rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : raddr();
            flush    = ($urandom_range(0, 19) == 0);
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : raddr();
            rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : raddr();
        end
        step();
        rst = 1'b0;
        idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, 32, data width of each register.
REQ-002 SHALL have parameter NREG, 32, number of architectural registers (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports rd_addr1, rd_addr2  input  AW  read port addresses.
REQ-006 SHALL have ports rd_data1, rd_data2  output  XLEN  read port data.
REQ-007 SHALL have ports wr_en input 1, wr_addr input AW, wr_data input XLEN: write/complete port.
REQ-008 SHALL have ports rsv_en input 1, rsv_addr input AW: reserve destination at issue.
REQ-009 SHALL have port flush  input  1  clear all reservations.
REQ-010 SHALL have ports busy1, busy2  output  1  pending-producer flag for each read address.
REQ-011 SHALL have port stall  output  1  busy1 OR busy2.
REQ-012 SHALL have port busy_cnt  output  AW+1  number of set busy bits.

Function
REQ-013 Reads SHALL be combinational, zero latency; address 0 SHALL always return 0 with busy 0.
REQ-014 wr_en with wr_addr!=0 SHALL load wr_data at the next edge; writes to address 0 SHALL be ignored.
REQ-015 Each register SHALL have a busy bit; rsv_en with rsv_addr!=0 SHALL set it at the next edge; reserving address 0 SHALL be ignored.
REQ-016 wr_en to a nonzero address SHALL clear that address's busy bit at the next edge.
REQ-017 Same-cycle reserve and write to the same address SHALL leave busy set (new producer wins); data is still written.
REQ-018 flush SHALL clear every busy bit at the next edge, overriding rsv_en in that cycle; register data is unaffected and a same-cycle write still lands.
REQ-019 Reserving an already-busy register SHALL keep it busy (no counting of multiple producers).
REQ-020 busy_cnt SHALL be a registered value equal to the popcount of the busy vector after each edge; range 0..NREG-1.
REQ-021 Both read ports SHALL operate independently, including when both address the same register.

Reset
REQ-022 rst SHALL asynchronously force all registers to 0, all busy bits to 0, busy_cnt to 0; hence rd_data*=0, busy*=0, stall=0.
REQ-023 rst asserted mid-operation SHALL discard pending reservations and in-flight writes of that cycle.

Configuration
REQ-024 Macro REG_FILE_SB_BYPASS_EN SHALL enable same-cycle write forwarding.
REQ-025 With it defined: when wr_en and wr_addr==rd_addrN!=0, rd_dataN SHALL equal wr_data and busyN SHALL be 0 unless rsv_en also targets that address in the same cycle.
REQ-026 Without it: rd_dataN and busyN SHALL reflect stored state only; written value visible the cycle after the edge.

Structure
REQ-027 Package rf_pkg SHALL hold XLEN/NREG defaults, the AW derivation function and the register-index typedef.
REQ-028 Busy-bit vector, its set/clear/flush priority and busy_cnt SHALL live in sub-module rf_scoreboard; the data array stays in reg_file_sb.

Verification
REQ-029 Reset then read x5/x31 -> rd_data=0, busy=0, busy_cnt=0.
REQ-030 Write x3=0xDEADBEEF; read x3 next cycle -> 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
REQ-031 Reserve x7; read x7 -> busy1=1, stall=1, busy_cnt=1; write x7=0x55 -> busy clear, busy_cnt=0.
REQ-032 Same cycle reserve x9 and write x9=0xA -> x9=0xA, busy stays 1; reserve x2,x4 then flush -> busy_cnt=0, data intact.
REQ-033 With BYPASS_EN: write x4=0x77 while reading x4 -> rd_data=0x77 same cycle, busy=0; without: old value returned.
REQ-034 Assert rst asynchronously between edges with x6 busy and x6=0x99 -> outputs 0 immediately, busy_cnt=0.
